// File: rtl/reg_bus_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NumReq requesters.
// One transaction is latched at a time. The response is passed straight back
// to the granted requester. A watchdog ends stalled transactions with an error.

// Per-requester lane: gates the requester's fields onto the shared mux and
// steers the completion strobe back to it.
module reg_bus_rr_lane #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   grant,
  input  logic                   valid,
  input  logic                   write,
  input  logic [AddrWidth-1:0]   addr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [DataWidth/8-1:0] wstrb,
  input  logic                   rsp_fire,
  output logic                   sel_valid,
  output logic                   sel_write,
  output logic [AddrWidth-1:0]   sel_addr,
  output logic [DataWidth-1:0]   sel_wdata,
  output logic [DataWidth/8-1:0] sel_wstrb,
  output logic                   rsp_ready
);
  assign sel_valid = grant & valid;
  assign sel_write = grant & write;
  assign sel_addr  = grant ? addr  : '0;
  assign sel_wdata = grant ? wdata : '0;
  assign sel_wstrb = grant ? wstrb : '0;
  assign rsp_ready = grant & rsp_fire;
endmodule

module reg_bus_rr_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] req_wstrb_i,
  output logic [NumReq-1:0]             rsp_ready_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          rsp_error_o,
  output logic                          reg_valid_o,
  output logic                          reg_write_o,
  output logic [AddrWidth-1:0]          reg_addr_o,
  output logic [DataWidth-1:0]          reg_wdata_o,
  output logic [DataWidth/8-1:0]        reg_wstrb_o,
  input  logic                          reg_ready_i,
  input  logic                          reg_error_i,
  input  logic [DataWidth-1:0]          reg_rdata_i,
  output logic [NumReq-1:0]             grant_o
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  // Counter value in the last BUSY cycle before the watchdog fires.
  localparam int unsigned  TmoLastI = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(TmoLastI);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NumReq-1:0] grant_q, grant_d;

  logic [NumReq-1:0]                lane_valid, lane_write, lane_rsp;
  logic [NumReq-1:0][AddrWidth-1:0] lane_addr;
  logic [NumReq-1:0][DataWidth-1:0] lane_wdata;
  logic [NumReq-1:0][StrbWidth-1:0] lane_wstrb;

  logic                 sel_write;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic [StrbWidth-1:0] sel_wstrb;

  logic            busy, granted_valid, abort, done, tmo, tmo_en, rsp_fire;
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  int              cand;

  for (genvar i = 0; i < NumReq; i++) begin : g_lane
    reg_bus_rr_lane #(
      .AddrWidth(AddrWidth),
      .DataWidth(DataWidth)
    ) u_lane (
      .grant    (grant_q[i]),
      .valid    (req_valid_i[i]),
      .write    (req_write_i[i]),
      .addr     (req_addr_i[i*AddrWidth +: AddrWidth]),
      .wdata    (req_wdata_i[i*DataWidth +: DataWidth]),
      .wstrb    (req_wstrb_i[i*StrbWidth +: StrbWidth]),
      .rsp_fire (rsp_fire),
      .sel_valid(lane_valid[i]),
      .sel_write(lane_write[i]),
      .sel_addr (lane_addr[i]),
      .sel_wdata(lane_wdata[i]),
      .sel_wstrb(lane_wstrb[i]),
      .rsp_ready(lane_rsp[i])
    );
  end

  // OR-combine the lanes; at most one lane is granted so this is the mux.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NumReq; i++) begin
      sel_write = sel_write | lane_write[i];
      sel_addr  = sel_addr  | lane_addr[i];
      sel_wdata = sel_wdata | lane_wdata[i];
      sel_wstrb = sel_wstrb | lane_wstrb[i];
    end
  end

  // Round-robin pick: first valid requester at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NumReq; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!pick_found && req_valid_i[IdxW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  // Transaction-ending events; abort beats completion beats timeout.
  assign busy          = (state_q == BUSY);
  assign tmo_en        = (TimeoutCycles > 0);
  assign granted_valid = |lane_valid;
  assign abort         = busy & ~granted_valid;
  assign done          = busy & granted_valid & reg_ready_i;
  assign tmo           = tmo_en & busy & granted_valid & ~reg_ready_i & (cnt_q == CntLast);
  assign rsp_fire      = done | tmo;

  assign reg_valid_o = busy & granted_valid;
  assign reg_write_o = sel_write;
  assign reg_addr_o  = sel_addr;
  assign reg_wdata_o = sel_wdata;
  assign reg_wstrb_o = sel_wstrb;
  assign rsp_ready_o = lane_rsp;
  assign rsp_rdata_o = done ? reg_rdata_i : '0;
  assign rsp_error_o = done ? reg_error_i : tmo;
  assign grant_o     = grant_q;

  // Next-state: grant on entry to BUSY, release and advance ptr on any end.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d           = BUSY;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          cnt_d             = '0;
        end
      end
      BUSY: begin
        if (abort || done || tmo) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == LastIdx) ? '0 : gidx_q + 1'b1;
        end else if (tmo_en && cnt_q != CntLast) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end
endmodule

// File: tb/tb_reg_bus_rr_arbiter.sv
// Directed bench for reg_bus_rr_arbiter with a scoreboard monitor and a
// small adder-style register target (0x00, 0x04 writable; 0x08 = sum).
module tb_reg_bus_rr_arbiter;
  logic              clk, rst;
  logic [1:0]        vld, wr;
  logic [1:0][31:0]  ad, wd;
  logic [1:0][3:0]   st;
  logic [1:0]        rsp_ready_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_error_o;
  logic              reg_valid_o, reg_write_o;
  logic [31:0]       reg_addr_o, reg_wdata_o;
  logic [3:0]        reg_wstrb_o;
  logic              reg_ready_i, reg_error_i;
  logic [31:0]       reg_rdata_i;
  logic [1:0]        grant_o;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  reg_bus_rr_arbiter #(.NumReq(2), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(vld), .req_write_i(wr), .req_addr_i(ad), .req_wdata_i(wd), .req_wstrb_i(st),
    .rsp_ready_o(rsp_ready_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i), .reg_error_i(reg_error_i), .reg_rdata_i(reg_rdata_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Register target model.
  logic [31:0] r0 = 32'h0;
  logic [31:0] r4 = 32'h0;
  int          wcnt = 0;
  int          tgt_waits = 0;
  bit          tgt_stuck = 1'b0;

  assign reg_ready_i = reg_valid_o && !tgt_stuck && (wcnt == tgt_waits);
  assign reg_error_i = reg_valid_o && (reg_addr_o >= 32'h10);
  assign reg_rdata_i = (!reg_valid_o || reg_write_o) ? 32'h0 :
                       (reg_addr_o == 32'h0) ? r0 :
                       (reg_addr_o == 32'h4) ? r4 :
                       (reg_addr_o == 32'h8) ? r0 + r4 : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reg_valid_o && !reg_ready_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (reg_valid_o && reg_ready_i && reg_write_o)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb_o[b]) begin
          if (reg_addr_o == 32'h0) r0[b*8 +: 8] <= reg_wdata_o[b*8 +: 8];
          if (reg_addr_o == 32'h4) r4[b*8 +: 8] <= reg_wdata_o[b*8 +: 8];
        end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every completion strobe pops the matching requester's queue.
  initial begin
    exp_t e;
    int   r;
    bit   have;
    forever begin
      @(negedge clk);
      if (!rst && rsp_ready_o != 2'b00) begin
        have = 1'b1;
        r    = 0;
        if (rsp_ready_o == 2'b01 && q0.size() > 0) e = q0.pop_front();
        else if (rsp_ready_o == 2'b10 && q1.size() > 0) begin e = q1.pop_front(); r = 1; end
        else begin
          have = 1'b0;
          checks++;
          fails++;
          $display("FAIL unexpected_rsp: rsp_ready=%b with nothing expected (cycle %0d)", rsp_ready_o, cyc);
        end
        if (have) begin
          chk($sformatf("rsp_rdata_req%0d", r), rsp_rdata_o, e.rdata);
          chk($sformatf("rsp_error_req%0d", r), rsp_error_o, e.err);
          chk($sformatf("rsp_cycle_req%0d", r), cyc, e.cyc);
          chk($sformatf("grant_at_rsp_req%0d", r), grant_o, (r == 0) ? 2'b01 : 2'b10);
        end
      end
    end
  end

  // Issue one request (caller is just past a rising edge, arbiter idle or
  // about to be), record its expected response, hold until ready, then drop.
  task automatic drive(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] erd, input logic eerr, input int lat);
    exp_t e;
    int   n;
    bit   got;
    e.rdata = erd;
    e.err   = eerr;
    e.cyc   = cyc + lat;
    if (r == 0) q0.push_back(e);
    else q1.push_back(e);
    wr[r] = w; ad[r] = a; wd[r] = d; st[r] = s; vld[r] = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (rsp_ready_o[r]) got = 1'b1;
      n++;
    end
    chk($sformatf("drive_done_req%0d", r), got, 1'b1);
    @(posedge clk);
    #1;
    vld[r] = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    vld = '0; wr = '0; ad = '0; wd = '0; st = '0;

    // Reset holds everything at zero even with a pending request.
    vld[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_reg_valid", reg_valid_o, 1'b0);
    chk("rst_rsp_ready", rsp_ready_o, 2'b00);
    vld[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single requester, zero-wait target.
    drive(0, 1'b1, 32'h0, 32'd5, 4'hF, 32'h0, 1'b0, 1);
    drive(0, 1'b1, 32'h4, 32'd7, 4'hF, 32'h0, 1'b0, 1);
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'd12, 1'b0, 1);
    drive(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1);
    // Byte-strobed write from req1: only byte 0 lands, r0 becomes 3; ptr -> 0.
    drive(1, 1'b1, 32'h0, 32'hFFFF_FF03, 4'h1, 32'h0, 1'b0, 1);

    // Contention with ptr=0, then both re-request: strict alternation.
    fork
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'd3, 1'b0, 1);
      drive(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'd7, 1'b0, 3);
    join
    fork
      drive(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'd10, 1'b0, 1);
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'd3, 1'b0, 3);
    join

    // Three wait states; the idle requester's fields churn meanwhile.
    tgt_waits = 3;
    ad[1] = 32'h0;
    fork
      drive(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'd7, 1'b0, 4);
      begin
        repeat (4) begin
          @(posedge clk);
          #1;
          ad[1] = ad[1] + 32'h100;
          wd[1] = ~wd[1];
          st[1] = ~st[1];
          @(negedge clk);
          chk("wait_addr_stable", reg_addr_o, 32'h4);
          chk("wait_reg_valid", reg_valid_o, 1'b1);
        end
      end
    join
    tgt_waits = 0;

    // Timeout with ptr=1: req1 stalls out, then pending req0 is granted.
    tgt_stuck = 1'b1;
    fork
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 16);
      drive(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'd10, 1'b0, 18);
      begin
        n = 0;
        repeat (17) begin
          @(negedge clk);
          if (reg_valid_o) n++;
        end
        chk("tmo_valid_cycles", n, 16);
        @(posedge clk);
        #1;
        tgt_stuck = 1'b0;
      end
    join

    // Abort: req1 (ptr=1) drops valid in cycle 2 while the target stalls.
    tgt_stuck = 1'b1;
    wr[1] = 1'b0; ad[1] = 32'h4; st[1] = 4'h0; vld[1] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_c1_reg_valid", reg_valid_o, 1'b1);
    chk("abort_c1_grant", grant_o, 2'b10);
    @(posedge clk);
    #1;
    vld[1] = 1'b0;
    @(negedge clk);
    chk("abort_c2_reg_valid", reg_valid_o, 1'b0);
    chk("abort_c2_rsp_ready", rsp_ready_o, 2'b00);
    @(posedge clk);
    #1;
    tgt_stuck = 1'b0;
    fork
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'd3, 1'b0, 1);
      drive(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'd7, 1'b0, 3);
    join

    // Move ptr to 1, then reset in the middle of a stalled req1 transaction.
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'd10, 1'b0, 1);
    tgt_stuck = 1'b1;
    wr[1] = 1'b1; ad[1] = 32'h8; wd[1] = 32'h1234_5678; st[1] = 4'hF; vld[1] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_reg_valid", reg_valid_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_reg_valid", reg_valid_o, 1'b0);
    chk("mid_rst_grant", grant_o, 2'b00);
    chk("mid_rst_addr", reg_addr_o, 32'h0);
    chk("mid_rst_wdata", reg_wdata_o, 32'h0);
    chk("mid_rst_wstrb", reg_wstrb_o, 4'h0);
    chk("mid_rst_write", reg_write_o, 1'b0);
    chk("mid_rst_rsp_ready", rsp_ready_o, 2'b00);
    vld[1] = 1'b0;
    tgt_stuck = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fork
      drive(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'd7, 1'b0, 1);
      drive(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'd10, 1'b0, 3);
    join

    repeat (3) @(posedge clk);
    chk("sb_q0_drained", q0.size(), 0);
    chk("sb_q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit exceeded");
  end
endmodule

// File: doc/reg_bus_rr_arbiter.md
# reg_bus_rr_arbiter

Round-robin arbiter that shares one register-bus target (e.g. the accelerator register file behind the APB-to-reg bridge) between several register-bus requesters. It latches one requester per transaction, forwards that request to the target, and routes the response back. A watchdog terminates stalled transactions with an error. It sits between the requesters and the single register-bus target port.

## Interface
- NumReq, 2, number of requesters (≥2)
- AddrWidth, 32, register-bus address width
- DataWidth, 32, register-bus data width (wstrb is DataWidth/8)
- TimeoutCycles, 16, maximum target wait in BUSY; 0 disables the watchdog
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  NumReq  per-requester valid
- req_write_i  in  NumReq  per-requester write flag
- req_addr_i  in  NumReq*AddrWidth  packed addresses, requester i at [i*AddrWidth +: AddrWidth]
- req_wdata_i  in  NumReq*DataWidth  packed write data
- req_wstrb_i  in  NumReq*DataWidth/8  packed byte strobes
- rsp_ready_o  out  NumReq  per-requester completion strobe
- rsp_rdata_o  out  DataWidth  shared read data, qualified by rsp_ready_o
- rsp_error_o  out  1  shared error, qualified by rsp_ready_o
- reg_valid_o, reg_write_o  out  1 each  target request
- reg_addr_o  out  AddrWidth; reg_wdata_o  out  DataWidth; reg_wstrb_o  out  DataWidth/8
- reg_ready_i, reg_error_i  in  1 each; reg_rdata_i  in  DataWidth  target response
- grant_o  out  NumReq  registered one-hot grant, 0 when idle

## Operation
- Protocol: a request holds valid and all fields stable until its ready. A transfer completes in the cycle where valid and ready are both high.
- State IDLE:
  - All target outputs are 0, rsp_ready_o is 0, and rsp_rdata_o/rsp_error_o are 0.
  - If any req_valid_i is high, select the first set bit searching upward from ptr with wrap-around.
  - Latch it into grant_o, clear the timeout counter, and go to BUSY.
- State BUSY, granted index g:
  - reg_valid_o=1. The write, addr, wdata and wstrb outputs are muxed from requester g.
  - Completion: if reg_ready_i=1, then rsp_ready_o[g]=1, rsp_rdata_o=reg_rdata_i and rsp_error_o=reg_error_i in the same cycle (combinational pass-through). Then ptr←(g+1) mod NumReq, grant_o←0, go to IDLE.
  - Timeout: if TimeoutCycles>0 and the counter equals TimeoutCycles-1 without reg_ready_i, then rsp_ready_o[g]=1, rsp_error_o=1, rsp_rdata_o=0. Advance ptr and go to IDLE. The counter otherwise increments each BUSY cycle.
  - Abort: if req_valid_i[g]=0 (protocol violation), reg_valid_o is forced to 0 that cycle and no rsp_ready_o is raised. Advance ptr and go to IDLE.
  - Priority when events coincide: abort > completion > timeout.
- Requests other than g are ignored while BUSY. They stay pending on their own valid.
- Counter width is $clog2(TimeoutCycles+1), with no wrap before timeout.

## Timing
- Reset (asynchronous, while rst_i=1) forces:
  - state=IDLE, ptr=0, counter=0, grant_o=0;
  - every output 0.
- Reset mid-BUSY drops reg_valid_o immediately and produces no response. After release the arbiter restarts from ptr=0.
- Latency from request valid at cycle 0 (arbiter IDLE):
  - grant registered at the edge ending cycle 0;
  - reg_valid_o=1 in cycle 1;
  - with a zero-wait target, rsp_ready_o high in cycle 1.
- Throughput: one transaction per 2 cycles minimum, because IDLE is always visited between transactions.
- With k target wait states, the response arrives in cycle 1+k.
- A timeout response arrives in cycle TimeoutCycles, so reg_valid_o is high for exactly TimeoutCycles cycles.
- Under continuous requests from all sources, no requester waits more than NumReq transactions.

## Test plan
- Single requester, zero-wait register target:
  - write 0x00←5, then 0x04←7 (wstrb 0xF), then read 0x08;
  - expect rsp_ready_o[0] in cycle 1 of each transaction, rdata=12, error=0, grant_o=2'b01.
- Contention: req 0 and req 1 both valid at cycle 0 with ptr=0.
  - req0 is served in cycle 1 and req1 in cycle 3.
  - Both re-request: req0 is served next (ptr=0), confirming strict alternation.
- Wait states: target holds reg_ready_i low for 3 cycles.
  - rsp_ready_o pulses in cycle 4 only.
  - reg_addr_o stays stable throughout, even if the other requester toggles its fields.
- Timeout with TimeoutCycles=16: target ready is stuck at 0.
  - At cycle 16, rsp_ready_o[g]=1 with error=1 and rdata=0.
  - The next cycle is IDLE, and the other pending requester is granted.
- Abort: the granted requester drops valid in cycle 2 while the target stalls.
  - reg_valid_o=0 that cycle, no rsp_ready_o, and ptr advances.
- Reset asserted mid-BUSY:
  - all outputs are 0 immediately;
  - after release, with both requesters valid, req0 is granted first.
